// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sram_stream_reader
//  Purpose  : Read-side streamer for the 64-bit dual-port solver SRAM.
//             On a start command it reads consecutive words from port B,
//             beginning at base_addr. Each word is split into two HBITS
//             elements, low half first. The elements go out on a
//             valid/ready stream. A 2-entry word FIFO absorbs the SRAM's
//             1-cycle read latency and downstream backpressure.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   clock, rising edge (shared with the SRAM)
//    RST        in   asynchronous active-high reset
//    start      in   command strobe, sampled only while idle
//    base_addr  in   first word address, latched on accepted start
//    len        in   element count, latched on accepted start
//    abort      in   (SRAM_STREAM_READER_ABORT_EN only) cancel running command
//    busy       out  high from accepted start until final element handshake
//    done       out  one-cycle completion pulse
//    CENB       out  SRAM port-B enable, active low (registered)
//    WENB       out  constant 2'b11, port B only reads
//    AB         out  SRAM port-B address (registered)
//    DB         out  constant 0
//    QB         in   SRAM port-B read data, valid the cycle after CENB low
//    o_data     out  element data
//    o_valid    out  element valid
//    o_ready    in   consumer ready
//    o_last     out  marks the final element of a command
// ----------------------------------------------------------------------------
//  Build option
//    SRAM_STREAM_READER_ABORT_EN : when defined, adds the abort input.
//    Without it, every accepted command runs to completion.
// ============================================================================
module sram_stream_reader #(
    parameter int BITS       = 64,
    parameter int HBITS      = BITS / 2,
    parameter int ADDR_WIDTH = 13,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
`ifdef SRAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  CENB,
    output logic [1:0]            WENB,
    output logic [ADDR_WIDTH-1:0] AB,
    output logic [BITS-1:0]       DB,
    input  logic [BITS-1:0]       QB,
    output logic [HBITS-1:0]      o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;

    // Read issue side
    logic                  cenb_q, cenb_d;
    logic [ADDR_WIDTH-1:0] ab_q, ab_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;          // next address to issue
    logic [LEN_WIDTH-1:0]  words_rem_q, words_rem_d; // words not yet issued
    logic                  cap_q, cap_d;             // QB carries a word this cycle

    // Emit side
    logic [LEN_WIDTH-1:0]  elem_rem_q, elem_rem_d;   // elements not yet accepted
    logic                  done_q, done_d;

    // 2-entry word FIFO
    logic [BITS-1:0]       fifo0_q, fifo0_d;
    logic [BITS-1:0]       fifo1_q, fifo1_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  half_q, half_d;           // 0: low half next, 1: high half next

    // Combinational helpers
    logic                  w_abort;
    logic                  w_accept;
    logic                  w_zero_cmd;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_final;
    logic                  w_issue_run;
    logic                  w_issue;
    logic [2:0]            w_occ_after;
    logic [2:0]            w_inflight;
    logic [LEN_WIDTH:0]    w_len_p1;
    logic [LEN_WIDTH-1:0]  w_words;
    logic [BITS-1:0]       w_head;

`ifdef SRAM_STREAM_READER_ABORT_EN
    assign w_abort = abort & (state_q == ST_RUN);
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign w_accept   = (state_q == ST_IDLE) & start & (len != '0);
    assign w_zero_cmd = (state_q == ST_IDLE) & start & (len == '0);

    // words = ceil(len/2); one extra bit keeps len+1 from overflowing
    assign w_len_p1 = {1'b0, len} + {{LEN_WIDTH{1'b0}}, 1'b1};
    assign w_words  = w_len_p1[LEN_WIDTH:1];

    // ------------------------------------------------------------------
    // Stream handshake and FIFO pop
    // ------------------------------------------------------------------
    assign w_hs    = o_valid & o_ready;
    assign w_last  = (elem_rem_q == LEN_WIDTH'(1));
    // A word leaves after its high half, or after its low half when that
    // low half is the final element of an odd-length command.
    assign w_pop   = w_hs & (half_q | w_last);
    assign w_final = w_hs & w_last & ~w_abort;

    // ------------------------------------------------------------------
    // Read issue
    // Occupancy is counted after this cycle's pop. Otherwise a word that
    // leaves this cycle would still block the next read, which would put
    // a bubble in the stream every other word.
    // ------------------------------------------------------------------
    assign w_occ_after = {1'b0, count_q} - {2'b00, w_pop};
    assign w_inflight  = {2'b00, ~cenb_q} + {2'b00, cap_q};
    assign w_issue_run = (state_q == ST_RUN) & ~w_abort & (words_rem_q != '0)
                       & ((w_occ_after + w_inflight) < 3'd2);
    // The first read goes out on the accepting edge itself.
    assign w_issue     = w_accept | w_issue_run;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort || w_final) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_q == ST_RUN);
        o_valid = (state_q == ST_RUN) & (count_q != 2'd0);
        o_last  = (state_q == ST_RUN) & (count_q != 2'd0) & w_last;
    end

    assign w_head = rd_ptr_q ? fifo1_q : fifo0_q;
    assign o_data = half_q ? w_head[BITS-1:HBITS] : w_head[HBITS-1:0];

    assign done = done_q;
    assign CENB = cenb_q;
    assign AB   = ab_q;
    assign WENB = 2'b11;
    assign DB   = '0;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cenb_d      = ~w_issue;
        ab_d        = ab_q;
        addr_d      = addr_q;
        words_rem_d = words_rem_q;
        elem_rem_d  = elem_rem_q;
        // A read issued in the abort cycle is not captured.
        cap_d       = ~cenb_q & ~w_abort;
        done_d      = w_zero_cmd | w_final;

        if (w_accept) begin
            ab_d        = base_addr;
            addr_d      = base_addr + ADDR_WIDTH'(1);
            words_rem_d = w_words - LEN_WIDTH'(1);
            elem_rem_d  = len;
        end else if (w_abort) begin
            words_rem_d = '0;
            elem_rem_d  = '0;
        end else begin
            if (w_issue_run) begin
                ab_d        = addr_q;
                // Natural wrap at 2**ADDR_WIDTH
                addr_d      = addr_q + ADDR_WIDTH'(1);
                words_rem_d = words_rem_q - LEN_WIDTH'(1);
            end
            if (w_hs) begin
                elem_rem_d = elem_rem_q - LEN_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO next-state
    // ------------------------------------------------------------------
    always_comb begin
        fifo0_d  = fifo0_q;
        fifo1_d  = fifo1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        half_d   = half_q;

        if (w_abort || w_final) begin
            // Leave the buffer clean for the next command.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            half_d   = 1'b0;
        end else begin
            if (cap_q) begin
                if (wr_ptr_q) begin
                    fifo1_d = QB;
                end else begin
                    fifo0_d = QB;
                end
                wr_ptr_d = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
                half_d   = 1'b0;
            end else if (w_hs) begin
                half_d   = 1'b1;
            end
            count_d = count_q + {1'b0, cap_q} - {1'b0, w_pop};
        end
    end

    // ------------------------------------------------------------------
    // Datapath and FIFO registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cenb_q      <= 1'b1;
            ab_q        <= '0;
            addr_q      <= '0;
            words_rem_q <= '0;
            elem_rem_q  <= '0;
            cap_q       <= 1'b0;
            done_q      <= 1'b0;
            fifo0_q     <= '0;
            fifo1_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            half_q      <= 1'b0;
        end else begin
            cenb_q      <= cenb_d;
            ab_q        <= ab_d;
            addr_q      <= addr_d;
            words_rem_q <= words_rem_d;
            elem_rem_q  <= elem_rem_d;
            cap_q       <= cap_d;
            done_q      <= done_d;
            fifo0_q     <= fifo0_d;
            fifo1_q     <= fifo1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            half_q      <= half_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_stream_reader
//  Purpose  : Self-checking bench for sram_stream_reader. It has a
//             behavioural SRAM, an element and address reference queue
//             built from each command, and a negedge monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_stream_reader;

    localparam int BITS  = 64;
    localparam int AW    = 13;
    localparam int LW    = AW + 2;
    localparam int DEPTH = 1 << AW;

    logic            CLK = 1'b0;
    logic            RST;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [LW-1:0]   len;
    logic            busy, done, CENB;
    logic [1:0]      WENB;
    logic [AW-1:0]   AB;
    logic [BITS-1:0] DB, QB;
    logic [31:0]     o_data;
    logic            o_valid, o_ready, o_last;
`ifdef SRAM_STREAM_READER_ABORT_EN
    logic            abort = 1'b0;
`endif

    sram_stream_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef SRAM_STREAM_READER_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .CENB      (CENB),
        .WENB      (WENB),
        .AB        (AB),
        .DB        (DB),
        .QB        (QB),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_last    (o_last)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM port B. Outside a read, QB carries garbage so a
    // capture at the wrong cycle shows up as bad data.
    logic [BITS-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (!CENB) QB <= mem[AB];
        else       QB <= {$urandom, $urandom};
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: expected element and read-address streams
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        word_end;
        logic        last;
        logic [31:0] data;
    } elem_t;

    elem_t         exp_q[$];
    logic [AW-1:0] exp_addr[$];
    logic          done_exp  = 1'b0;
    logic          mon_skip  = 1'b0;
    int            issued    = 0;
    int            words_done = 0;
    int            hs_count  = 0;
    logic          stall_prev = 1'b0;
    logic [31:0]   prev_data;
    logic          prev_last;

    always @(negedge CLK) begin
        if (RST) begin
            chk_eq("rst_valid", o_valid, 0);
            chk_eq("rst_busy",  busy,    0);
            chk_eq("rst_done",  done,    0);
            chk_eq("rst_cenb",  CENB,    1);
            stall_prev = 1'b0;
            done_exp   = 1'b0;
        end else if (mon_skip) begin
            stall_prev = 1'b0;
        end else begin
            chk_eq("busy", busy, exp_q.size() != 0);
            chk_eq("done", done, done_exp);
            done_exp = 1'b0;
            if (!CENB) begin
                chk_eq("read_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) begin
                    logic [AW-1:0] a;
                    a = exp_addr.pop_front();
                    chk_eq("AB", AB, a);
                end
                issued++;
                chk_eq("outstanding_le2", (issued - words_done) <= 2, 1);
            end
            if (stall_prev) begin
                chk_eq("stall_valid", o_valid, 1);
                chk_eq("stall_data",  o_data,  prev_data);
                chk_eq("stall_last",  o_last,  prev_last);
            end
            if (o_valid && o_ready) begin
                chk_eq("elem_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    elem_t e;
                    e = exp_q.pop_front();
                    chk_eq("o_data", o_data, e.data);
                    chk_eq("o_last", o_last, e.last);
                    if (e.word_end) words_done++;
                    if (e.last) done_exp = 1'b1;
                    hs_count++;
                end
            end
            stall_prev = o_valid & !o_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    // Called just after a rising edge (inputs change at posedge + 1).
    task automatic issue_cmd(input int base, input int n);
        start     = 1'b1;
        base_addr = AW'(base);
        len       = LW'(n);
        @(posedge CLK); #1;
        start = 1'b0;
        issued = 0; words_done = 0; hs_count = 0;
        if (n == 0) begin
            done_exp = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                elem_t e;
                logic [63:0] w;
                w = mem[(base + i / 2) % DEPTH];
                e.word_end = (i % 2 == 1) || (i == n - 1);
                e.last     = (i == n - 1);
                e.data     = (i % 2 == 1) ? w[63:32] : w[31:0];
                exp_q.push_back(e);
            end
            for (int k = 0; k < (n + 1) / 2; k++) exp_addr.push_back(AW'((base + k) % DEPTH));
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_addr.delete();
        done_exp = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: random plus one 10-cycle stall
    task automatic wait_done(input int mode);
        int budget;
        int hold;
        bit held;
        budget = exp_q.size() * 20 + 60;
        hold = 0;
        held = 0;
        while ((exp_q.size() != 0 || busy) && budget > 0) begin
            if (mode == 0) o_ready = 1'b1;
            else if (mode == 2 && !held && hs_count >= 4) begin
                hold = 10; held = 1;
            end
            if (hold > 0) begin
                o_ready = 1'b0; hold--;
            end else if (mode != 0) begin
                o_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge CLK); #1;
            budget--;
        end
        chk_eq("cmd_completes", budget > 0, 1);
        o_ready = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        chk_eq("addr_all_read", exp_addr.size(), 0);
        clear_model();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        mem[5] = 64'h0000000B_0000000A;
        mem[6] = 64'h0000000D_0000000C;

        RST = 1'b1; start = 1'b0; base_addr = '0; len = '0; o_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_eq("rst_odata", o_data, 0);
        chk_eq("rst_ab",    AB,     0);
        chk_eq("rst_last",  o_last, 0);
        RST = 1'b0;

        // Idle: nothing moves for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk_eq("idle_cenb",  CENB,    1);
            chk_eq("idle_wenb",  WENB,    2'b11);
            chk_eq("idle_valid", o_valid, 0);
            chk_eq("idle_busy",  busy,    0);
        end
        chk_eq("db_zero", DB, 0);
        @(posedge CLK); #1;

        // Even burst, cycle-exact latency and throughput
        o_ready = 1'b1;
        issue_cmd(5, 4);
        @(negedge CLK);
        chk_eq("lat_cenb0",   CENB,    0);
        chk_eq("lat_ab0",     AB,      5);
        chk_eq("lat_valid_e0", o_valid, 0);
        @(negedge CLK);
        chk_eq("lat_valid_e1", o_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk_eq("burst_valid", o_valid, 1);
            chk_eq("burst_data",  o_data,  32'hA + 32'(i));
            chk_eq("burst_last",  o_last,  i == 3);
        end
        @(negedge CLK);
        chk_eq("burst_done", done, 1);
        @(posedge CLK); #1;
        wait_done(0);

        // Odd length with address wrap
        issue_cmd(DEPTH - 1, 3);
        wait_done(0);

        // Backpressure
        issue_cmd($urandom_range(0, DEPTH - 1), 8);
        wait_done(2);

        // Random commands
        for (int r = 0; r < 6; r++) begin
            issue_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 24));
            wait_done(1);
        end

        // Zero length: done next cycle, no read
        issue_cmd(77, 0);
        repeat (4) begin @(posedge CLK); #1; end

        // Start during RUN is ignored
        issue_cmd(100, 10);
        repeat (3) begin o_ready = $urandom_range(0, 1); @(posedge CLK); #1; end
        start = 1'b1; base_addr = AW'(7); len = LW'(5);
        @(posedge CLK); #1;
        start = 1'b0;
        wait_done(1);

        // Reset mid-burst
        issue_cmd(200, 16);
        for (int t = 0; t < 40 && hs_count < 3; t++) begin @(posedge CLK); #1; end
        chk_eq("reached_3_elems", hs_count >= 3, 1);
        RST = 1'b1;
        clear_model();
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        issue_cmd(300, 2);
        wait_done(0);

`ifdef SRAM_STREAM_READER_ABORT_EN
        // Abort mid-burst
        issue_cmd(400, 16);
        for (int t = 0; t < 40 && hs_count < 3; t++) begin @(posedge CLK); #1; end
        chk_eq("abort_reached_3", hs_count >= 3, 1);
        abort = 1'b1; o_ready = 1'b0; mon_skip = 1'b1;
        clear_model();
        @(posedge CLK); #1;
        abort = 1'b0; mon_skip = 1'b0; o_ready = 1'b1;
        @(negedge CLK);
        chk_eq("abort_valid", o_valid, 0);
        chk_eq("abort_busy",  busy,    0);
        @(posedge CLK); #1;
        issue_cmd(500, 2);
        wait_done(0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Downstream consumer of the 64-bit dual-port solver SRAM; drives read port B only.
- On a start command, reads consecutive words from a base address and unpacks each word into two 32-bit elements, low half first.
- Emits the elements on a valid/ready stream to the solver datapath.
- Absorbs the SRAM's 1-cycle registered read latency and downstream backpressure with a small word buffer.

Parameters:
- BITS, 64, SRAM word width; must be even.
- HBITS, BITS/2, element width and output data width.
- ADDR_WIDTH, 13, SRAM address width (WORD_DEPTH = 2**ADDR_WIDTH).
- LEN_WIDTH, ADDR_WIDTH+2, width of the element-count input; holds up to 2*WORD_DEPTH.

Ports:
- CLK  input  1  single clock, rising edge; same clock as the SRAM.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address; latched on accepted start.
- len  input  LEN_WIDTH  element count; latched on accepted start.
- busy  output  1  high from the accepted start until the final element handshake.
- done  output  1  one-cycle pulse on completion.
- CENB  output  1  SRAM port-B enable, active low.
- WENB  output  2  constant 2'b11 (read only).
- AB  output  ADDR_WIDTH  SRAM port-B address.
- DB  output  BITS  constant 0.
- QB  input  BITS  SRAM port-B read data; valid the cycle after CENB is low.
- o_data  output  HBITS  element data.
- o_valid  output  1  element valid.
- o_ready  input  1  consumer ready.
- o_last  output  1  high with the final element of a command.

Behaviour:
- Reset values:
  - busy = 0, done = 0, o_valid = 0, o_last = 0, o_data = 0.
  - CENB = 1, AB = 0.
  - Buffer empty, credit = 0, state IDLE.
- States:
  - IDLE -> RUN on start=1 with len != 0. Latch base_addr and len. Compute words = ceil(len/2).
  - IDLE with start=1 and len == 0: no SRAM access; done pulses on the next cycle; remain in IDLE.
  - RUN -> IDLE on the handshake (o_valid & o_ready) of element len-1. done pulses the cycle after that handshake.
- start while busy is ignored. base_addr and len are sampled only on an accepted start.
- Read issue:
  - In RUN, CENB=0 and AB=next address when words_remaining > 0 and (buffer occupancy + reads in flight) < 2.
  - CENB and AB are registered outputs.
  - The address increments by 1 per issued read and wraps modulo 2**ADDR_WIDTH (address 8191 is followed by 0).
- Capture: QB is written into a 2-entry word FIFO in the cycle following the issue cycle. QB is ignored in every other cycle.
- Unpack:
  - The FIFO head drives o_data = head[HBITS-1:0] first, then head[BITS-1:HBITS].
  - The head word is popped after its high half is accepted.
  - Odd len: the final word emits only its low half, with o_last=1, then is popped.
- Latency: with start accepted at edge 0, CENB is low after edge 0 and o_valid first rises after edge 2.
- Throughput: sustains 1 element/cycle while o_ready=1.
- Stream rules:
  - o_data, o_valid and o_last are held stable while o_valid=1 and o_ready=0.
  - o_valid never drops without a handshake.
- Width rules: element counter and word counter are LEN_WIDTH bits; no overflow for len <= 2*WORD_DEPTH.
- Reset mid-operation returns all state to reset values immediately. Outstanding SRAM data is discarded.
- Port A is never driven by this block. Write collisions are the owner of port A's responsibility.

Optional Feature:
- Macro: SRAM_STREAM_READER_ABORT_EN.
- With macro: adds input abort (1 bit).
  - abort=1 in RUN stops read issue the same cycle and flushes the FIFO.
  - Any in-flight QB is discarded.
  - o_valid drops the next cycle; done is not pulsed.
  - State returns to IDLE one cycle later.
  - abort in IDLE has no effect. abort has priority over a coincident final handshake.
- Without macro: no abort port; commands always run to completion.

Test Plan:
- Reset/idle: RST=1 then 0, no start -> CENB=1, WENB=2'b11, o_valid=0, busy=0, done=0 for 20 cycles.
- Even burst: SRAM preloaded mem[5]=64'h0000000B_0000000A, mem[6]=64'h0000000D_0000000C; start with base_addr=5, len=4, o_ready=1 -> o_data sequence A,B,C,D on consecutive cycles, o_last on D, first o_valid 2 cycles after start edge, done 1 cycle after D.
- Odd length plus wrap: base_addr=8191, len=3 -> reads AB=8191 then 0; elements mem[8191][31:0], mem[8191][63:32], mem[0][31:0]; o_last on third; no read of address 1.
- Backpressure: len=8, o_ready toggled randomly (and held low 10 cycles mid-burst) -> in-order elements with no loss or duplication, o_data stable while stalled, at most 2 reads outstanding plus buffered at any time.
- Corner commands: len=0 -> done pulse next cycle, CENB never low. start asserted during RUN -> ignored, current burst completes unchanged.
- Reset mid-burst (and abort with SRAM_STREAM_READER_ABORT_EN): assert RST (or abort) after 3 elements of len=16 -> o_valid=0 next cycle, busy=0, no done pulse. A new start with len=2 then returns the correct 2 elements.
